// File: rtl/riscv_muldiv_pkg.sv
// riscv_muldiv_pkg
// Shared definitions for the elastic RV32M/RV64M mul/div pipeline:
//   - MD_* function codes carried on req_fn
//   - result-packing classes and the XLEN-wide slot positions used by the
//     writeback mux ({hi slot, lo slot})
//   - legal ranges for the XLEN and DEPTH parameters
package riscv_muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_DIV    = 3'd1;
    localparam logic [2:0] MD_DIVU   = 3'd2;
    localparam logic [2:0] MD_REM    = 3'd3;
    localparam logic [2:0] MD_REMU   = 3'd4;
    localparam logic [2:0] MD_MULH   = 3'd5;
    localparam logic [2:0] MD_MULHSU = 3'd6;
    localparam logic [2:0] MD_MULHU  = 3'd7;

    // Slot index in units of XLEN inside the 2*XLEN response word.
    localparam int unsigned PK_LO_SLOT = 0;
    localparam int unsigned PK_HI_SLOT = 1;

    localparam int XLEN_RV32 = 32;
    localparam int XLEN_RV64 = 64;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 8;

    typedef enum logic [1:0] {
        PK_FULL  = 2'd0,   // {hi, lo} full product
        PK_MULHI = 2'd1,   // {hi, 0}
        PK_QUOT  = 2'd2,   // {0, quotient}
        PK_REM   = 2'd3    // {remainder, 0}
    } md_pack_e;

    function automatic md_pack_e md_pack_of(input logic [2:0] fn);
        md_pack_e p;
        case (fn)
            MD_MUL:                        p = PK_FULL;
            MD_MULH, MD_MULHSU, MD_MULHU:  p = PK_MULHI;
            MD_DIV, MD_DIVU:               p = PK_QUOT;
            default:                       p = PK_REM;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/riscv_muldiv_compute.sv
// riscv_muldiv_compute
// Combinational multiply/divide core with RISC-V corner-case handling and
// result packing. Sits between pipeline stage S0 and S1.
// Ports:
//   fn_i      MD_* function code
//   a_i, b_i  operands (rs1, rs2), XLEN bits
//   result_o  packed 2*XLEN result
module riscv_muldiv_compute
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        fn_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ZERO    = '0;
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};

    logic                      a_sgn_mul;
    logic                      b_sgn_mul;
    logic signed [2*XLEN+1:0]  a_mul;
    logic signed [2*XLEN+1:0]  b_mul;
    logic signed [2*XLEN+1:0]  prod_full;
    logic [2*XLEN-1:0]         prod;
    logic                      unused_prod_msbs;

    logic                      div_signed;
    logic                      a_neg;
    logic                      b_neg;
    logic [XLEN-1:0]           a_mag;
    logic [XLEN-1:0]           b_mag;
    logic [XLEN-1:0]           b_div;
    logic [XLEN-1:0]           q_mag;
    logic [XLEN-1:0]           r_mag;
    logic [XLEN-1:0]           quot;
    logic [XLEN-1:0]           rem;

    // One signed multiplier covers all four multiply flavours: each operand
    // is sign- or zero-extended to 2*XLEN+2 bits so the low 2*XLEN bits of
    // the product are exact. MUL uses the unsigned product for its high half.
    always_comb begin
        a_sgn_mul = (fn_i == MD_MULH) || (fn_i == MD_MULHSU);
        b_sgn_mul = (fn_i == MD_MULH);
        a_mul     = {{(XLEN+2){a_sgn_mul & a_i[XLEN-1]}}, a_i};
        b_mul     = {{(XLEN+2){b_sgn_mul & b_i[XLEN-1]}}, b_i};
    end

    assign prod_full        = a_mul * b_mul;
    assign prod             = prod_full[2*XLEN-1:0];
    assign unused_prod_msbs = ^prod_full[2*XLEN+1:2*XLEN];

    // Signed divide is done on magnitudes, then the signs are restored.
    always_comb begin
        div_signed = (fn_i == MD_DIV) || (fn_i == MD_REM);
        a_neg      = div_signed & a_i[XLEN-1];
        b_neg      = div_signed & b_i[XLEN-1];
        a_mag      = a_neg ? -a_i : a_i;
        b_mag      = b_neg ? -b_i : b_i;
        // Divisor forced non-zero so the divider never sees x/0.
        b_div      = (b_mag == ZERO) ? ONE : b_mag;
        q_mag      = a_mag / b_div;
        r_mag      = a_mag % b_div;
        quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem        = a_neg ? -r_mag : r_mag;

        if (b_i == ZERO) begin
            quot = '1;
            rem  = a_i;
        end else if (div_signed && (a_i == MIN_NEG) && (b_i == '1)) begin
            quot = a_i;
            rem  = ZERO;
        end
    end

    always_comb begin
        result_o = '0;
        unique case (md_pack_of(fn_i))
            PK_FULL:  result_o = prod;
            PK_MULHI: result_o[PK_HI_SLOT*XLEN +: XLEN] = prod[PK_HI_SLOT*XLEN +: XLEN];
            PK_QUOT:  result_o[PK_LO_SLOT*XLEN +: XLEN] = quot;
            PK_REM:   result_o[PK_HI_SLOT*XLEN +: XLEN] = rem;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_core_muldiv_pipe_elastic.sv
// riscv_core_muldiv_pipe_elastic
// Fully pipelined RV32M/RV64M mul/div unit with per-stage elastic flow
// control, bubble collapsing, tagged responses and synchronous flush.
// Stage S0 holds the operands; the arithmetic is combinational into S1;
// S1..S(DEPTH-1) carry {result, tag}; the last stage drives resp_*.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_val/req_rdy             request handshake
//   req_fn, req_a, req_b        op code and operands
//   req_tag                     tag returned with the result
//   resp_val/resp_rdy           response handshake
//   resp_result, resp_tag       packed 2*XLEN result and its tag
//   flush                       drop every in-flight op
//   busy                        any stage holds a valid op
// Optional: define RISCV_MULDIV_PERF_CNT_EN to add perf_ops (response
// handshakes) and perf_stall (cycles with resp_val & ~resp_rdy).
module riscv_core_muldiv_pipe_elastic
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_val,
    output logic                req_rdy,
    input  logic [2:0]          req_fn,
    input  logic [XLEN-1:0]     req_a,
    input  logic [XLEN-1:0]     req_b,
    input  logic [TAG_W-1:0]    req_tag,
    output logic                resp_val,
    input  logic                resp_rdy,
    output logic [2*XLEN-1:0]   resp_result,
    output logic [TAG_W-1:0]    resp_tag,
    input  logic                flush,
    output logic                busy
`ifdef RISCV_MULDIV_PERF_CNT_EN
    ,
    output logic [31:0]         perf_ops,
    output logic [31:0]         perf_stall
`endif
);

    if ((XLEN != XLEN_RV32) && (XLEN != XLEN_RV64)) begin : g_bad_xlen
        $error("riscv_core_muldiv_pipe_elastic: XLEN must be 32 or 64");
    end
    if ((DEPTH < DEPTH_MIN) || (DEPTH > DEPTH_MAX)) begin : g_bad_depth
        $error("riscv_core_muldiv_pipe_elastic: DEPTH must be in 2..8");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("riscv_core_muldiv_pipe_elastic: TAG_W must be at least 1");
    end

    logic [DEPTH-1:0]    stage_v;
    logic [DEPTH-1:0]    adv;
    logic [2*XLEN-1:0]   stage_res [DEPTH];
    logic [TAG_W-1:0]    stage_tag [DEPTH];
    logic                accept;

    // A stage may advance when it is empty or its successor advances; the
    // running OR from the output back gives that without a self-referencing
    // vector, and lets empty stages keep filling behind a stalled output.
    always_comb begin
        logic acc;
        adv = '0;
        acc = resp_rdy;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc    = acc | ~stage_v[k];
            adv[k] = acc;
        end
    end

    assign req_rdy = adv[0] & ~flush;
    assign accept  = req_val & req_rdy;

    // S0: operand capture
    logic              s0_v_q, s0_v_d;
    logic [2:0]        fn_q, fn_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [TAG_W-1:0]  tag0_q, tag0_d;

    always_comb begin
        s0_v_d = s0_v_q;
        fn_d   = fn_q;
        a_d    = a_q;
        b_d    = b_q;
        tag0_d = tag0_q;
        if (adv[0]) begin
            s0_v_d = accept;
        end
        if (accept) begin
            fn_d   = req_fn;
            a_d    = req_a;
            b_d    = req_b;
            tag0_d = req_tag;
        end
        if (flush) begin
            s0_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_v_q <= 1'b0;
            fn_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            tag0_q <= '0;
        end else begin
            s0_v_q <= s0_v_d;
            fn_q   <= fn_d;
            a_q    <= a_d;
            b_q    <= b_d;
            tag0_q <= tag0_d;
        end
    end

    riscv_muldiv_compute #(
        .XLEN (XLEN)
    ) u_compute (
        .fn_i     (fn_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (stage_res[0])
    );

    assign stage_v[0]   = s0_v_q;
    assign stage_tag[0] = tag0_q;

    // S1..S(DEPTH-1): {result, tag}. Data only moves when the predecessor is
    // valid, so an idle output keeps showing the last result.
    for (genvar k = 1; k < DEPTH; k++) begin : g_stage
        logic              v_q, v_d;
        logic [2*XLEN-1:0] res_q, res_d;
        logic [TAG_W-1:0]  tag_q, tag_d;

        always_comb begin
            v_d   = v_q;
            res_d = res_q;
            tag_d = tag_q;
            if (adv[k]) begin
                v_d = stage_v[k-1];
                if (stage_v[k-1]) begin
                    res_d = stage_res[k-1];
                    tag_d = stage_tag[k-1];
                end
            end
            if (flush) begin
                v_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q   <= 1'b0;
                res_q <= '0;
                tag_q <= '0;
            end else begin
                v_q   <= v_d;
                res_q <= res_d;
                tag_q <= tag_d;
            end
        end

        assign stage_v[k]   = v_q;
        assign stage_res[k] = res_q;
        assign stage_tag[k] = tag_q;
    end

    assign resp_val    = stage_v[DEPTH-1];
    assign resp_result = stage_res[DEPTH-1];
    assign resp_tag    = stage_tag[DEPTH-1];
    assign busy        = |stage_v;

`ifdef RISCV_MULDIV_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (resp_val & resp_rdy) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
        if (resp_val & ~resp_rdy) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
